iob_eth_dma_r: RTL and testbench
================================

// Module: iob_eth_dma_r
// PURPOSE
// - AXI4 read-master DMA that fetches a frame payload from system memory into the Ethernet TX buffer.
// - Reads dma_len bytes starting at an arbitrary byte address dma_addr.
// - Realigns the bytes so that payload byte 0 lands in byte lane 0 of buffer word BUF_START.
// - Sits between the system AXI interconnect and the TX frame RAM; it is the counterpart of the RX write DMA.
// PARAMETERS
// - AXI_ADDR_W  32   AXI address width
// - AXI_DATA_W  32   AXI data width; only 32 is supported
// - MAX_BURST   16   Maximum beats per AR burst; power of two, 1..256
// - BUF_START   4    First TX buffer word address written
// PORTS
// - clk            in   1       Clock
// - rst            in   1       Asynchronous reset, active-high
// - m_axi_arid     out  ID_W    Constant 0
// - m_axi_araddr   out  ADDR_W  Burst start address, word aligned
// - m_axi_arlen    out  8       Beats-1
// - m_axi_arsize   out  3       Constant 3'h2
// - m_axi_arburst  out  2       Constant 2'b01 (INCR)
// - m_axi_arlock   out  1       Constant 0
// - m_axi_arcache  out  4       Constant 4'h2
// - m_axi_arprot   out  3       Constant 3'b010
// - m_axi_arqos    out  4       Constant 0
// - m_axi_arvalid  out  1       Address valid
// - m_axi_arready  in   1       Address ready
// - m_axi_rdata    in   32      Read data
// - m_axi_rresp    in   2       Read response
// - m_axi_rlast    in   1       Last beat of burst
// - m_axi_rvalid   in   1       Read data valid
// - m_axi_rready   out  1       Read data ready
// - dma_addr       in   ADDR_W  Source byte address; sampled on start
// - dma_len        in   10      Byte count 0..1023; sampled on start
// - dma_run        in   1       Start pulse; honoured only while dma_ready=1
// - dma_ready      out  1       Idle / transfer done
// - dma_error      out  1       Sticky error for the last transfer (see CONFIGURATION)
// - buf_wdata      out  32      TX buffer write data
// - buf_waddr      out  9       TX buffer word address
// - buf_wr         out  1       TX buffer write strobe, one word per cycle
// BEHAVIOUR
// - Reset values: dma_ready=1; m_axi_arvalid=0, m_axi_rready=0; araddr=0, arlen=0;
//   buf_wr=0, buf_waddr=0, buf_wdata=0; dma_error=0.
// - Reset mid-transfer aborts immediately; outstanding AXI beats are not drained.
// - Start: dma_run & dma_ready latches off=dma_addr[1:0], waddr=dma_addr&~3, len.
//   The same start edge sets dma_ready=0 and clears dma_error.
// - Derived counts: beats=(off+len+3)>>2 (11 bit); words=(len+3)>>2.
// - States:
//   - IDLE: on start -> CALC, or -> DONE if len=0 (no AXI traffic, no buffer writes).
//   - CALC: n=min(beats_left, MAX_BURST, (4096-waddr[11:0])>>2). Bursts never cross a 4KB boundary.
//     Sets araddr=waddr, arlen=n-1, arvalid=1 -> ADDR.
//   - ADDR: hold arvalid and araddr/arlen stable until arready; then arvalid=0, rready=1 -> DATA.
//   - DATA: rready held 1. Each rvalid&rready beat decrements beats_left; waddr += 4 per beat.
//     On the rlast beat: rready=0, then -> CALC if beats_left>0;
//     else -> FLUSH if words_written<words, else -> DONE.
//   - FLUSH: one buffer write of the held partial word -> DONE.
//   - DONE: dma_ready=1 -> IDLE.
// - Realignment: prev holds the previous beat.
//   - off=0: every beat is written as-is.
//   - off!=0: the first beat is only stored. Each later beat writes {beat[8*off-1:0], prev[31:8*off]}.
//     FLUSH writes {0, prev[31:8*off]}.
// - Buffer write timing: buf_wr pulses the cycle after the producing beat (registered).
//   - buf_waddr starts at BUF_START and increments after each write.
//   - Exactly `words` writes occur per transfer.
// - Final word: bytes at positions >= len are forced to 0.
// - rlast is trusted for burst end; beat count is cross-checked only under the macro.
// CONFIGURATION
// - IOB_ETH_DMA_R_ERR_EN defined:
//   - dma_error sets on any accepted beat with rresp!=2'b00.
//   - dma_error also sets when rlast disagrees with the expected beat count.
//   - The transfer still completes and buffer writes continue.
// - IOB_ETH_DMA_R_ERR_EN not defined: rresp is ignored and dma_error is tied 0.
// TESTING
// - Memory: 0x100=0x44332211, 0x104=0x88776655.
// - 1. Aligned: addr=0x100, len=8 -> one AR (araddr=0x100, arlen=1); buf[4]=0x44332211, buf[5]=0x88776655.
// - 2. Unaligned: addr=0x103, len=5 -> arlen=1; buf[4]=0x77665544, buf[5]=0x00000088 via FLUSH.
// - 3. 4KB split, MAX_BURST=16: addr=0xFF8, len=16 -> AR 0xFF8/arlen=1 then AR 0x1000/arlen=1;
//      4 writes, buf_waddr 4..7.
// - 4. len=0 -> no arvalid, no buf_wr; dma_ready low exactly 2 cycles. dma_run while busy is ignored.
// - 5. rvalid toggled 1/0 per cycle -> output data identical to case 2; rst asserted mid-DATA -> all outputs at reset values.
// - 6. With macro: rresp=2'b10 on the 2nd beat of case 1 -> dma_error=1 at DONE, both words still written.

Source files
------------

// File: rtl/iob_eth_dma_r.sv
// AXI4 read-master DMA: fetches dma_len bytes from an arbitrary byte address and writes them,
// realigned to lane 0, into the TX buffer from word BUF_START. Error reporting: IOB_ETH_DMA_R_ERR_EN.
module iob_eth_dma_r #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int MAX_BURST  = 16,
    parameter int BUF_START  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [AXI_ADDR_W-1:0] dma_addr,
    input  logic [9:0]            dma_len,
    input  logic                  dma_run,
    output logic                  dma_ready,
    output logic                  dma_error,
    output logic [AXI_DATA_W-1:0] buf_wdata,
    output logic [8:0]            buf_waddr,
    output logic                  buf_wr
);

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, FLUSH, DONE} state_t;

    localparam logic [10:0] MAX_B = 11'(MAX_BURST);

    state_t                  state, state_nxt;
    logic [1:0]              off;
    logic [AXI_ADDR_W-1:0]   waddr;
    logic [9:0]              len_q;
    logic [10:0]             beats_left, beats_left_dec;
    logic [8:0]              words, issued, issued_nxt;
    logic                    first_q;
    logic [AXI_DATA_W-1:0]   prev_p0;
    logic [10:0]             room_w, n_burst;
    logic                    start, beat, wr_beat;

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = 3'h2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'h2;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'h0;

    // Shift the byte stream so that payload byte 0 lands in lane 0.
    function automatic logic [31:0] realign(input logic [31:0] cur, input logic [31:0] prv,
                                            input logic [1:0] o);
        case (o)
            2'd1:    return {cur[7:0],  prv[31:8]};
            2'd2:    return {cur[15:0], prv[31:16]};
            2'd3:    return {cur[23:0], prv[31:24]};
            default: return cur;
        endcase
    endfunction

    function automatic logic [31:0] mask_tail(input logic [31:0] d, input logic [8:0] idx,
                                              input logic [9:0] len);
        logic [31:0] r;
        r = d;
        for (int b = 0; b < 4; b++)
            if (({idx, 2'b00} + 11'(b)) >= {1'b0, len}) r[8*b +: 8] = 8'h00;
        return r;
    endfunction

    // Burst size: bounded by remaining beats, MAX_BURST and the next 4KB boundary.
    assign room_w = 11'd1024 - 11'(waddr[11:2]);
    always_comb begin
        n_burst = beats_left;
        if (n_burst > MAX_B)  n_burst = MAX_B;
        if (n_burst > room_w) n_burst = room_w;
    end

    always_comb begin
        start          = dma_run & dma_ready & (state == IDLE);
        beat           = (state == DATA) & m_axi_rvalid & m_axi_rready;
        wr_beat        = beat & ((off == 2'd0) | ~first_q) & (issued < words);
        issued_nxt     = issued + 9'(wr_beat);
        beats_left_dec = (beats_left == 11'd0) ? 11'd0 : beats_left - 11'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (dma_len == 10'd0) ? DONE : CALC;
            CALC:  state_nxt = ADDR;
            ADDR:  if (m_axi_arready) state_nxt = DATA;
            DATA:
                if (beat && m_axi_rlast) begin
                    if (beats_left_dec != 11'd0) state_nxt = CALC;
                    else if (issued_nxt < words) state_nxt = FLUSH;
                    else                         state_nxt = DONE;
                end
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_ready     <= 1'b1;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= 8'd0;
            buf_wr        <= 1'b0;
            buf_waddr     <= 9'd0;
            buf_wdata     <= '0;
            off           <= 2'd0;
            waddr         <= '0;
            len_q         <= 10'd0;
            beats_left    <= 11'd0;
            words         <= 9'd0;
            issued        <= 9'd0;
            first_q       <= 1'b1;
            prev_p0       <= '0;
        end else begin
            buf_wr    <= 1'b0;
            // Ready rises one cycle after returning to IDLE.
            dma_ready <= dma_ready ? ~start : (state == IDLE);
            if (start) begin
                off        <= dma_addr[1:0];
                waddr      <= {dma_addr[AXI_ADDR_W-1:2], 2'b00};
                len_q      <= dma_len;
                beats_left <= (11'(dma_addr[1:0]) + 11'(dma_len) + 11'd3) >> 2;
                words      <= 9'((11'(dma_len) + 11'd3) >> 2);
                issued     <= 9'd0;
                first_q    <= 1'b1;
            end
            if (state == CALC) begin
                m_axi_araddr  <= waddr;
                m_axi_arlen   <= 8'(n_burst - 11'd1);
                m_axi_arvalid <= 1'b1;
            end
            if (state == ADDR && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b1;
            end
            // Beat stage -> buffer write stage
            if (beat) begin
                beats_left <= beats_left_dec;
                waddr      <= waddr + AXI_ADDR_W'(4);
                prev_p0    <= m_axi_rdata;
                first_q    <= 1'b0;
                if (m_axi_rlast) m_axi_rready <= 1'b0;
            end
            if (wr_beat) begin
                buf_wr    <= 1'b1;
                buf_wdata <= mask_tail(realign(m_axi_rdata, prev_p0, off), issued, len_q);
                buf_waddr <= 9'(BUF_START) + issued;
                issued    <= issued_nxt;
            end else if (state == FLUSH) begin
                buf_wr    <= 1'b1;
                buf_wdata <= mask_tail(realign(32'h0, prev_p0, off), issued, len_q);
                buf_waddr <= 9'(BUF_START) + issued;
                issued    <= issued + 9'd1;
            end
        end
    end

`ifdef IOB_ETH_DMA_R_ERR_EN
    logic [8:0] burst_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_left <= 9'd0;
            dma_error  <= 1'b0;
        end else begin
            if (state == CALC) burst_left <= 9'(n_burst);
            else if (beat && burst_left != 9'd0) burst_left <= burst_left - 9'd1;
            if (start) dma_error <= 1'b0;
            else if (beat && ((m_axi_rresp != 2'b00) || (m_axi_rlast != (burst_left == 9'd1))))
                dma_error <= 1'b1;
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
    assign dma_error    = 1'b0;
`endif

endmodule

// File: tb/tb_iob_eth_dma_r.sv
// Bench for iob_eth_dma_r: AXI read slave over a byte memory, byte-stream reference model,
// per-cycle compare of AR bursts and buffer writes, plus literal checks of the reference cases.
module tb_iob_eth_dma_r;
    localparam int MAX_BURST = 16;
    localparam int BUF_START = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] dma_addr = '0;
    logic [9:0]  dma_len = '0;
    logic        dma_run = 1'b0;
    logic        dma_ready;
    logic        dma_error;
    logic [31:0] buf_wdata;
    logic [8:0]  buf_waddr;
    logic        buf_wr;

    always #5 clk = ~clk;

    iob_eth_dma_r #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(1),
                    .MAX_BURST(MAX_BURST), .BUF_START(BUF_START)) dut (
        .clk(clk), .rst(rst),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dma_addr(dma_addr), .dma_len(dma_len), .dma_run(dma_run),
        .dma_ready(dma_ready), .dma_error(dma_error),
        .buf_wdata(buf_wdata), .buf_waddr(buf_waddr), .buf_wr(buf_wr)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;

    logic [7:0] mem [0:8191];
    ar_t exp_ar[$], cap_ar[$];
    wr_t exp_wr[$], cap_wr[$];
    int  n_cmp = 0, n_err = 0;
    int  gap_mode = 0, ar_mode = 0, inj_at = -1, srv_beats = 0;
    int  low_cnt = 0, last_low = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: bursts split at MAX_BURST and 4KB; words are the byte stream, zero past len.
    task automatic model_push(input logic [31:0] a, input int l);
        int off, beats, n, room;
        logic [31:0] w, d;
        off = int'(a[1:0]);
        w = a & ~32'h3;
        beats = (off + l + 3) / 4;
        while (beats > 0) begin
            room = (4096 - int'(w % 4096)) / 4;
            n = beats;
            if (n > MAX_BURST) n = MAX_BURST;
            if (n > room) n = room;
            exp_ar.push_back('{w, 8'(n - 1)});
            w = w + 32'(4 * n);
            beats -= n;
        end
        for (int k = 0; k < (l + 3) / 4; k++) begin
            d = '0;
            for (int b = 0; b < 4; b++)
                if (4 * k + b < l) d[8*b +: 8] = mem[int'(a) + 4 * k + b];
            exp_wr.push_back('{9'(BUF_START + k), d});
        end
    endtask

    // AXI read slave: handshakes sampled at negedge, outputs updated just after posedge.
    initial begin : slave
        logic [31:0] bq_addr[$];
        int bq_len[$];
        int bi, w;
        bit ar_hs, r_hs, present;
        bi = 0;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (ar_hs) begin
                bq_addr.push_back(m_axi_araddr);
                bq_len.push_back(int'(m_axi_arlen) + 1);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                bq_addr.delete(); bq_len.delete(); bi = 0;
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
            end else begin
                m_axi_arready = (ar_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (r_hs) begin
                    bi++; srv_beats++;
                    if (bi == bq_len[0]) begin
                        void'(bq_addr.pop_front()); void'(bq_len.pop_front()); bi = 0;
                    end
                end
                if (!m_axi_rvalid || r_hs) begin
                    present = (bq_addr.size() > 0) &&
                              (gap_mode == 0 || (gap_mode == 1 && !m_axi_rvalid) ||
                               (gap_mode == 2 && $urandom_range(0, 1) == 1));
                    if (present) begin
                        w = int'(bq_addr[0]) + 4 * bi;
                        m_axi_rdata  = {mem[w+3], mem[w+2], mem[w+1], mem[w]};
                        m_axi_rlast  = (bi == bq_len[0] - 1);
                        m_axi_rresp  = (srv_beats == inj_at) ? 2'b10 : 2'b00;
                        m_axi_rvalid = 1'b1;
                    end else begin
                        m_axi_rvalid = 1'b0;
                        m_axi_rlast  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        ar_t ea;
        wr_t ew;
        forever begin
            @(negedge clk);
            if (rst) low_cnt = 0;
            else begin
                if (!dma_ready) low_cnt++;
                else begin
                    if (low_cnt > 0) last_low = low_cnt;
                    low_cnt = 0;
                end
                if (m_axi_arvalid)
                    check("ar_const", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                       m_axi_arcache, m_axi_arprot, m_axi_arqos},
                          {1'b0, 3'h2, 2'b01, 1'b0, 4'h2, 3'b010, 4'h0});
                if (m_axi_arvalid && m_axi_arready) begin
                    cap_ar.push_back('{m_axi_araddr, m_axi_arlen});
                    if (exp_ar.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL ar_extra: got araddr %0h, required no burst", m_axi_araddr);
                    end else begin
                        ea = exp_ar.pop_front();
                        check("araddr", m_axi_araddr, ea.addr);
                        check("arlen", m_axi_arlen, ea.len);
                    end
                end
                if (buf_wr) begin
                    cap_wr.push_back('{buf_waddr, buf_wdata});
                    if (exp_wr.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL wr_extra: got write %0h@%0h, required no write", buf_wdata, buf_waddr);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("buf_waddr", buf_waddr, ew.addr);
                        check("buf_wdata", buf_wdata, ew.data);
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, dma_ready, 1);
        check({tag, "_arvalid"}, m_axi_arvalid, 0);
        check({tag, "_rready"}, m_axi_rready, 0);
        check({tag, "_araddr"}, m_axi_araddr, 0);
        check({tag, "_arlen"}, m_axi_arlen, 0);
        check({tag, "_buf_wr"}, buf_wr, 0);
        check({tag, "_buf_waddr"}, buf_waddr, 0);
        check({tag, "_buf_wdata"}, buf_wdata, 0);
        check({tag, "_error"}, dma_error, 0);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int l, input logic exp_err, input bit hold);
        int t;
        cap_ar.delete(); cap_wr.delete();
        srv_beats = 0;
        model_push(a, l);
        @(posedge clk); #1;
        dma_addr = a; dma_len = 10'(l); dma_run = 1'b1;
        @(posedge clk); #1;
        // Busy now: new parameters and run pulses must be ignored.
        dma_addr = $urandom; dma_len = 10'($urandom);
        dma_run = hold ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        dma_run = 1'b0;
        t = 0;
        while (t < 20000 && !dma_ready) begin
            @(negedge clk);
            t++;
        end
        if (!dma_ready) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: dma_ready still 0 after %0d cycles, required 1", t);
        end
        check("exp_ar_left", 64'(exp_ar.size()), 0);
        check("exp_wr_left", 64'(exp_wr.size()), 0);
        check("dma_error", dma_error, exp_err);
        exp_ar.delete(); exp_wr.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        logic [31:0] a;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} = 32'h44332211;
        {mem[32'h107], mem[32'h106], mem[32'h105], mem[32'h104]} = 32'h88776655;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        @(posedge clk); #1;
        rst = 1'b0;

        // Aligned
        run_xfer(32'h100, 8, 1'b0, 1'b0);
        check("t1_nar", 64'(cap_ar.size()), 1);
        check("t1_ar0", {cap_ar[0].addr, cap_ar[0].len}, {32'h100, 8'd1});
        check("t1_nwr", 64'(cap_wr.size()), 2);
        check("t1_w0", {cap_wr[0].addr, cap_wr[0].data}, {9'd4, 32'h44332211});
        check("t1_w1", {cap_wr[1].addr, cap_wr[1].data}, {9'd5, 32'h88776655});

        // Unaligned with flush
        run_xfer(32'h103, 5, 1'b0, 1'b0);
        check("t2_ar0", {cap_ar[0].addr, cap_ar[0].len}, {32'h100, 8'd1});
        check("t2_w0", {cap_wr[0].addr, cap_wr[0].data}, {9'd4, 32'h77665544});
        check("t2_w1", {cap_wr[1].addr, cap_wr[1].data}, {9'd5, 32'h00000088});

        // 4KB boundary split
        run_xfer(32'hFF8, 16, 1'b0, 1'b0);
        check("t3_nar", 64'(cap_ar.size()), 2);
        check("t3_ar0", {cap_ar[0].addr, cap_ar[0].len}, {32'hFF8, 8'd1});
        check("t3_ar1", {cap_ar[1].addr, cap_ar[1].len}, {32'h1000, 8'd1});
        check("t3_nwr", 64'(cap_wr.size()), 4);
        for (int k = 0; k < 4; k++) check("t3_waddr", cap_wr[k].addr, 9'(4 + k));

        // Zero length, run held while busy
        run_xfer(32'h100, 0, 1'b0, 1'b1);
        check("t4_nar", 64'(cap_ar.size()), 0);
        check("t4_nwr", 64'(cap_wr.size()), 0);
        check("t4_ready_low", 64'(last_low), 2);

        // Toggled rvalid reproduces the unaligned case
        gap_mode = 1;
        run_xfer(32'h103, 5, 1'b0, 1'b0);
        check("t5_w0", {cap_wr[0].addr, cap_wr[0].data}, {9'd4, 32'h77665544});
        check("t5_w1", {cap_wr[1].addr, cap_wr[1].data}, {9'd5, 32'h00000088});

`ifdef IOB_ETH_DMA_R_ERR_EN
        gap_mode = 0;
        inj_at = 1;
        run_xfer(32'h100, 8, 1'b1, 1'b0);
        check("t6_w0", {cap_wr[0].addr, cap_wr[0].data}, {9'd4, 32'h44332211});
        check("t6_w1", {cap_wr[1].addr, cap_wr[1].data}, {9'd5, 32'h88776655});
        inj_at = -1;
`endif

        // Reset in the middle of the data phase
        gap_mode = 2;
        cap_wr.delete();
        model_push(32'h201, 400);
        @(posedge clk); #1;
        dma_addr = 32'h201; dma_len = 10'd400; dma_run = 1'b1;
        @(posedge clk); #1;
        dma_run = 1'b0;
        t = 0;
        while (t < 3000 && !(cap_wr.size() >= 3 && m_axi_rready)) begin
            @(negedge clk);
            t++;
        end
        check("t5_reached_data", m_axi_rready, 1);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        exp_ar.delete(); exp_wr.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized transfers
        for (int i = 0; i < 20; i++) begin
            gap_mode = $urandom_range(0, 2);
            ar_mode  = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) a = 32'(4096 - $urandom_range(1, 64));
            else                           a = 32'($urandom_range(0, 7000));
            run_xfer(a, $urandom_range(0, 1023), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
